// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational
// instruction memory, and buffers {pc, word} pairs in a 2-entry queue
// that decode drains.
//
// Handshake: the head entry transfers on a rising edge where
// inst_valid && inst_ready are both high. inst_valid never depends on
// inst_ready. The head is held stable until it is accepted or a redirect
// flushes the queue. A pop on a redirect edge still counts as accepted.
module inst_fetch #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EBREAK_WORD = 32'h0010_0073
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0][31:0] ent_pc_q;
  logic [1:0][31:0] ent_word_q;

  logic pop;
  logic push;

  // Redirect targets are word aligned; the low bits are deliberately dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pop  = inst_valid & inst_ready;
  assign push = (state_q == RUN) & ~redirect_valid & ((count_q != 2'd2) | pop);

  assign imem_addr  = pc_q[ADDR_W+1:2];
  assign inst_valid = (count_q != 2'd0);
  assign inst       = ent_word_q[head_q];
  assign inst_pc    = ent_pc_q[head_q];
  assign halted     = (state_q == HALT);

  // Next-state logic: redirect flushes everything, otherwise push/pop bookkeeping.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        tail_d = ~tail_q;
        if (imem_data == EBREAK_WORD) state_d = HALT;
      end
      if (pop) head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Queue storage: capture the fetched word and its PC at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_pc_q   <= '0;
      ent_word_q <= '0;
    end else if (push) begin
      ent_pc_q[tail_q]   <= pc_q;
      ent_word_q[tail_q] <= imem_data;
    end
  end

endmodule
